// File: rtl/maj_bist_pkg.sv
// Shared types and sizing helpers for the majority-netlist BIST sweeper and its reference model.
package maj_bist_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Strict majority: more than half of the inputs must be high.
  function automatic int maj_threshold(input int n);
    return n / 2 + 1;
  endfunction

  // Bits needed to hold a popcount in the range 0..n.
  function automatic int clog2_cnt(input int n);
    int w;
    w = 0;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/maj_ref_popcount.sv
// Combinational majority reference: high when the popcount of x reaches the strict-majority threshold.
module maj_ref_popcount
  import maj_bist_pkg::*;
#(
  parameter int N = 43
) (
  input  logic [N-1:0] x,
  output logic         y_ref
);

  localparam int            PW     = clog2_cnt(N);
  localparam logic [PW-1:0] THRESH = PW'(maj_threshold(N));

  logic [PW-1:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + PW'(x[i]);
    end
  end

  assign y_ref = (count >= THRESH);

endmodule

// File: rtl/maj_bist_sweeper.sv
// Sweeps a contiguous range of vectors into a majority netlist, compares each settled y_in
// against the popcount reference, and reports a saturating mismatch count plus the first failing vector.
module maj_bist_sweeper
  import maj_bist_pkg::*;
#(
  parameter int N      = 43,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     start_vec,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N-1:0]     x_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             first_fail_valid,
  output logic [N-1:0]     first_fail_vec
);

  localparam int            SW            = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE - 1);

  state_t           state, state_next;
  logic [SW-1:0]    settle_cnt;
  logic [CNT_W-1:0] remaining;
  logic             y_ref;
  logic             sample_edge;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] mism_inc;

  maj_ref_popcount #(.N(N)) u_ref (
    .x     (x_out),
    .y_ref (y_ref)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (num_vec != '0)) state_next = RUN;
      RUN:  if (abort || (settle_cnt == '0 && last_vec)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort outranks sampling, so an aborted in-flight vector is never scored.
  always_comb begin
    busy        = (state == RUN);
    sample_edge = (state == RUN) && !abort && (settle_cnt == '0);
    mismatch    = (y_in != y_ref);
    last_vec    = (remaining <= CNT_W'(1));
    mism_inc    = (mism_cnt == '1) ? mism_cnt : mism_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out            <= '0;
      settle_cnt       <= '0;
      remaining        <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mism_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mism_cnt         <= '0;
            first_fail_valid <= 1'b0;
            remaining        <= num_vec;
            if (num_vec == '0) begin
              done <= 1'b1;
              pass <= 1'b1;
            end else begin
              pass       <= 1'b0;
              x_out      <= start_vec;
              settle_cnt <= SETTLE_RELOAD;
            end
          end
        end
        RUN: begin
          if (abort) begin
            x_out <= '0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (!sample_edge) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else begin
            if (mismatch) begin
              mism_cnt <= mism_inc;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= x_out;
              end
            end
            remaining <= remaining - CNT_W'(1);
            if (!last_vec) begin
              x_out      <= x_out + N'(1);
              settle_cnt <= SETTLE_RELOAD;
            end else begin
              x_out <= '0;
              done  <= 1'b1;
              pass  <= mismatch ? (mism_inc == '0) : (mism_cnt == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maj_bist_sweeper.sv
// Scoreboard bench for maj_bist_sweeper driving a bench-side majority netlist with selectable faults.
module tb_maj_bist_sweeper;

  localparam int N      = 43;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 48;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N-1:0]     start_vec = '0;
  logic [CNT_W-1:0] num_vec = '0;
  logic [N-1:0]     x_out;
  logic             y_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mism_cnt;
  logic             first_fail_valid;
  logic [N-1:0]     first_fail_vec;

  // 0: correct majority, 1: stuck-at-0, 2: threshold off by one (popcount >= 21)
  int dut_mode = 0;

  typedef struct {
    longint           cyc;
    logic [CNT_W-1:0] mism;
    logic             pass;
    logic             ffv;
    logic [N-1:0]     ffvec;
  } exp_t;

  exp_t   sb_q[$];
  longint cyc = 0;
  int     compared = 0;
  int     mismatched = 0;

  maj_bist_sweeper #(.N(N), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .start_vec        (start_vec),
    .num_vec          (num_vec),
    .x_out            (x_out),
    .y_in             (y_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mism_cnt         (mism_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (dut_mode)
      1:       y_in = 1'b0;
      2:       y_in = ($countones(x_out) >= 21);
      default: y_in = ($countones(x_out) >= 22);
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller sits at a negedge; returns #1 after the accepting edge with the expectation queued.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [CNT_W-1:0] n, input int delta,
                               input logic [CNT_W-1:0] em, input logic ep, input logic ev,
                               input logic [N-1:0] efv, input bit push);
    exp_t e;
    start_vec = v;
    num_vec   = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.cyc   = cyc + longint'(delta);
      e.mism  = em;
      e.pass  = ep;
      e.ffv   = ev;
      e.ffvec = efv;
      sb_q.push_back(e);
    end
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checkOutput("done_unexpected", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("mism_cnt", 64'(mism_cnt), 64'(e.mism));
        checkOutput("pass", 64'(pass), 64'(e.pass));
        checkOutput("first_fail_valid", 64'(first_fail_valid), 64'(e.ffv));
        if (e.ffv) checkOutput("first_fail_vec", 64'(first_fail_vec), 64'(e.ffvec));
        checkOutput("x_out_idle", 64'(x_out), 64'd0);
        checkOutput("busy_idle", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_x_out", 64'(x_out), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pass", 64'(pass), 64'd0);
    checkOutput("rst_mism", 64'(mism_cnt), 64'd0);
    checkOutput("rst_ffv", 64'(first_fail_valid), 64'd0);
    checkOutput("rst_ffvec", 64'(first_fail_vec), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep of 1000 vectors against a correct majority netlist
    dut_mode = 0;
    applyStimulus('0, 1000, 2000, 0, 1'b1, 1'b0, '0, 1'b1);
    waitDone(2100);
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);

    // Stuck-at-0: only the 22-ones vector 0x3FFFFF is a true majority
    dut_mode = 1;
    applyStimulus(43'h3F_FFFF, 4, 8, 1, 1'b0, 1'b1, 43'h3F_FFFF, 1'b1);
    waitDone(50);

    // Wrap from all-ones to zero
    @(negedge clk);
    applyStimulus('1, 2, 4, 1, 1'b0, 1'b1, '1, 1'b1);
    checkOutput("wrap_v0", 64'(x_out), 64'h7FF_FFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("wrap_v1", 64'(x_out), 64'd0);
    checkOutput("wrap_busy", 64'(busy), 64'd1);
    waitDone(20);

    // Threshold boundary, each start issued in the cycle the previous done is high
    dut_mode = 2;
    @(negedge clk);
    applyStimulus(43'h1F_FFFF, 1, 2, 1, 1'b0, 1'b1, 43'h1F_FFFF, 1'b1);
    waitDone(10);
    applyStimulus(43'h3F_FFFF, 1, 2, 0, 1'b1, 1'b0, '0, 1'b1);
    waitDone(10);
    applyStimulus(43'h7F_FFFF, 1, 2, 0, 1'b1, 1'b0, '0, 1'b1);
    waitDone(10);

    // Empty sweep
    @(negedge clk);
    applyStimulus(43'h5, 0, 0, 0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("empty_busy", 64'(busy), 64'd0);
    waitDone(5);
    checkOutput("empty_busy_done", 64'(busy), 64'd0);

    // start while busy must not restart or reload num_vec
    dut_mode = 0;
    @(negedge clk);
    applyStimulus('0, 3, 6, 0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    start_vec = 43'h3F_FFFF;
    num_vec   = 100;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(20);
    @(negedge clk);
    checkOutput("busy_after_ignored_start", 64'(busy), 64'd0);

    // Abort before E0+7 with one mismatch already counted
    dut_mode = 1;
    @(negedge clk);
    applyStimulus(43'h3F_FFFF, 10, 7, 1, 1'b0, 1'b1, 43'h3F_FFFF, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    waitDone(5);
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_done_low", 64'(done), 64'd0);
    checkOutput("abort_mism_hold", 64'(mism_cnt), 64'd1);
    checkOutput("abort_pass_hold", 64'(pass), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_idle_ignored", 64'(done), 64'd0);

    // Asynchronous reset mid-sweep
    dut_mode = 0;
    @(negedge clk);
    applyStimulus(43'h123, 100, 0, 0, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_x_out", 64'(x_out), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    checkOutput("arst_mism", 64'(mism_cnt), 64'd0);
    checkOutput("arst_ffv", 64'(first_fail_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_done", 64'(done), 64'd0);

    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/maj_bist_sweeper.md
# maj_bist_sweeper

Sequential on-chip stimulus generator and checker for the mapped N-input majority netlists (`top`, ports `x0..x{N-1}`, `y0`). It drives a contiguous range of input vectors into the DUT and samples `y0` after a fixed settle time. Each sample is compared against a popcount-threshold reference, and the block reports a mismatch count and the first failing vector. This gives hardware- and emulation-speed coverage of the vector sweeps that simulation benches cannot reach for large N.

## Interface
- `N`, 43, majority width; reference output is 1 iff popcount ≥ N/2+1 (integer division; strict majority for even N).
- `SETTLE`, 2, clock cycles each vector is held before `y_in` is sampled; legal range ≥1.
- `CNT_W`, 48, width of the vector-count and mismatch counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: terminate a running sweep.
- `start_vec` in N: first vector; captured at start.
- `num_vec` in CNT_W: number of vectors to check; captured at start.
- `x_out` out N: vector driven to DUT bits `x0..x{N-1}` (bit i → `xi`).
- `y_in` in 1: DUT `y0`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: last sweep completed with zero mismatches and no abort.
- `mism_cnt` out CNT_W: mismatches in the current/last sweep; saturates at all-ones.
- `first_fail_valid` out 1: `first_fail_vec` holds a captured vector.
- `first_fail_vec` out N: first vector whose `y_in` differed from the reference.

## Operation
- FSM states: IDLE, RUN.
- IDLE + `start`: capture `num_vec`, clear `mism_cnt` and `first_fail_valid`.
  - `num_vec`=0: stay in IDLE, pulse `done`, set `pass`=1.
  - Otherwise: `x_out`←`start_vec`, settle counter←SETTLE−1, remaining←`num_vec`, enter RUN, `busy`=1.
- RUN, settle counter ≠ 0: decrement.
- RUN, settle counter = 0 (sample edge):
  - compare `y_in` with `ref(x_out)`;
  - on mismatch, increment `mism_cnt` (saturating);
  - on the first mismatch, also load `first_fail_vec`←`x_out` and set `first_fail_valid`;
  - decrement remaining.
- Sample edge with remaining > 1: `x_out`←`x_out`+1 mod 2^N (all-ones wraps to 0); reload settle counter.
- Sample edge with remaining = 1: go to IDLE, `busy`←0, `done`←1, `pass`←(final `mism_cnt`==0), `x_out`←0.
- `abort` in RUN has priority over sampling:
  - go to IDLE, `x_out`←0, pulse `done`, `pass`←0;
  - `mism_cnt` and `first_fail_*` hold their values; the in-flight vector is not checked.
- `start` during RUN: ignored. `abort` in IDLE: ignored.
- `pass`, `mism_cnt`, `first_fail_*` hold after `done` until the next accepted `start`.
- Reference is combinational on registered `x_out`: popcount over N bits, width ⌈log2(N+1)⌉, compared against the constant N/2+1.

## Timing
- Reset values: `x_out`=0, `busy`=0, `done`=0, `pass`=0, `mism_cnt`=0, `first_fail_valid`=0, `first_fail_vec`=0, state IDLE.
- Reset mid-sweep returns all outputs to these values immediately; there is no `done` pulse.
- `start` accepted at edge E0: `x_out`=`start_vec` and `busy`=1 from E0.
- Vector k (k=0..num_vec−1) is sampled at edge E0+(k+1)·SETTLE; `x_out` changes at the same edge.
- `done`/`pass`/final `mism_cnt` are registered at E0+num_vec·SETTLE; `done` is high for exactly one cycle.
- `num_vec`=0: `done` is high in the cycle after E0.
- `abort` high before edge Ea: state is IDLE and `done`=1 after Ea.
- A new `start` is accepted in the same cycle `done` is high.

## Structure
- Package `maj_bist_pkg` holds:
  - state enum {IDLE, RUN};
  - function `maj_threshold(N)` = N/2+1;
  - function `clog2_cnt(N)` for the popcount width.
- Sub-module `maj_ref_popcount` (parameter N): combinational popcount ≥ threshold → `y_ref`. It is reused by other benches.
- Top-level integration wraps `top` and `maj_bist_sweeper` in a harness.

## Test plan
- Correct majority DUT, N=43, SETTLE=2, `start_vec`=0, `num_vec`=1000 → `done` at E0+2000, `mism_cnt`=0, `pass`=1, `first_fail_valid`=0.
- Stuck-at-0 DUT, `start_vec`=0x3FFFFF (22 ones), `num_vec`=4 → `mism_cnt`=1, `first_fail_vec`=0x3FFFFF, `pass`=0.
- Wrap: stuck-at-0 DUT, `start_vec`=all-ones, `num_vec`=2 → second vector observed as 0, `mism_cnt`=1, `first_fail_vec`=all-ones.
- Threshold boundary, DUT computing popcount ≥21, vectors with popcounts 21/22/23 → exactly the popcount-21 vector is flagged; popcount 22/23 pass.
- `num_vec`=0 → `done` one cycle after `start`, `busy` never 1, `pass`=1. `start` while busy is ignored (`num_vec` unchanged).
- `abort` at E0+7 with SETTLE=2 → `done` pulse, `pass`=0, `x_out`=0, `mism_cnt` holds. `rst_n` low mid-sweep → all outputs 0 asynchronously, no `done`.
